// File: rtl/sevseg_pkg.sv
// sevseg_pkg: shared digit codes, limits and formatter FSM states for the seven-segment path.
package sevseg_pkg;
    typedef logic [4:0] digit_code_t;
    localparam digit_code_t CODE_MINUS      = 5'd16;
    localparam digit_code_t CODE_UNDERSCORE = 5'd17;
    localparam digit_code_t CODE_U          = 5'd18;
    localparam digit_code_t CODE_DASH       = 5'd31;
    localparam int MAX_POS     = 9999;
    localparam int MAX_NEG_MAG = 999;
    typedef enum logic [1:0] {IDLE, SHIFT, FORMAT} fmt_state_t;
endpackage

// File: rtl/dd_digit_adj.sv
// dd_digit_adj: double-dabble BCD corrector, adds 3 to a digit that is 5 or more.
// Ports: d = BCD digit before shift, q = corrected digit.
module dd_digit_adj (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/signed_dec_formatter.sv
// signed_dec_formatter: signed binary to four seven-segment digit codes via sequential double-dabble.
// Ports: clk, rst_n (async, active-low); value_i/valid_i/ready_o accept handshake;
// done_o pulses when dig3_o..dig0_o update. Macro SEVSEG_HEX_MODE_EN adds hex_i (raw nibble display).
module signed_dec_formatter
    import sevseg_pkg::*;
#(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] value_i,
`ifdef SEVSEG_HEX_MODE_EN
    input  logic         hex_i,
`endif
    input  logic         valid_i,
    output logic         ready_o,
    output logic         done_o,
    output logic [4:0]   dig3_o,
    output logic [4:0]   dig2_o,
    output logic [4:0]   dig1_o,
    output logic [4:0]   dig0_o
);
    fmt_state_t state, state_d;
    logic sign, ovf, go_hex;
    logic [W-1:0] mag, sh, abs_v;
    logic [19:0] bcd, adj;
    logic [20+W-1:0] nxt;
    logic [4:0] cnt;
    digit_code_t [3:0] dq, fmt;

`ifdef SEVSEG_HEX_MODE_EN
    logic hex_q;
    logic [15:0] hx;
    assign go_hex = hex_i;
    assign hx = 16'(mag);
`else
    assign go_hex = 1'b0;
`endif

    for (genvar i = 0; i < 5; i++) begin : g_adj
        dd_digit_adj u_adj (.d(bcd[4*i +: 4]), .q(adj[4*i +: 4]));
    end

    // mag is W-bit unsigned so the most negative input still fits
    assign abs_v = value_i[W-1] ? W'(-value_i) : value_i;
    assign nxt = {adj, sh} << 1;
    // overflow is judged on the kept magnitude, so the BCD top digit needs no inspection
    assign ovf = sign ? 32'(mag) > MAX_NEG_MAG : 32'(mag) > MAX_POS;
    assign ready_o = state == IDLE;
    assign {dig3_o, dig2_o, dig1_o, dig0_o} = dq;

    always_comb begin
        fmt = ovf ? {4{CODE_DASH}}
            : sign ? {CODE_MINUS, 1'b0, bcd[11:8], 1'b0, bcd[7:4], 1'b0, bcd[3:0]}
            : {1'b0, bcd[15:12], 1'b0, bcd[11:8], 1'b0, bcd[7:4], 1'b0, bcd[3:0]};
`ifdef SEVSEG_HEX_MODE_EN
        if (hex_q) fmt = {1'b0, hx[15:12], 1'b0, hx[11:8], 1'b0, hx[7:4], 1'b0, hx[3:0]};
`endif
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (valid_i) state_d = go_hex ? FORMAT : SHIFT;
            SHIFT:   if (cnt == 5'd1) state_d = FORMAT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign   <= 1'b0;
            mag    <= '0;
            sh     <= '0;
            bcd    <= '0;
            cnt    <= '0;
            dq     <= {4{CODE_DASH}};
            done_o <= 1'b0;
`ifdef SEVSEG_HEX_MODE_EN
            hex_q  <= 1'b0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: if (valid_i) begin
                    sign  <= value_i[W-1];
                    mag   <= go_hex ? value_i : abs_v;
                    sh    <= abs_v;
                    bcd   <= '0;
                    cnt   <= 5'(W);
`ifdef SEVSEG_HEX_MODE_EN
                    hex_q <= hex_i;
`endif
                end
                SHIFT: begin
                    {bcd, sh} <= nxt;
                    cnt       <= cnt - 5'd1;
                end
                default: begin
                    dq     <= fmt;
                    done_o <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_signed_dec_formatter.sv
// tb_signed_dec_formatter: directed scoreboard bench for signed_dec_formatter (W=12 and W=16 instances).
module tb_signed_dec_formatter;
    localparam int W = 12;
    localparam logic [19:0] DASH4 = {4{5'd31}};

    logic clk = 1'b0, rst_n = 1'b0;
    logic [W-1:0] value_i = '0;
    logic valid_i = 1'b0;
    logic ready_o, done_o;
    logic [4:0] d3, d2, d1, d0;
    logic [15:0] v16 = '0;
    logic valid16 = 1'b0;
    logic ready16, done16;
    logic [4:0] e3, e2, e1, e0;
`ifdef SEVSEG_HEX_MODE_EN
    logic hex_i = 1'b0;
`endif

    int checks = 0, fails = 0;
    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    signed_dec_formatter #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .value_i(value_i),
`ifdef SEVSEG_HEX_MODE_EN
        .hex_i(hex_i),
`endif
        .valid_i(valid_i), .ready_o(ready_o), .done_o(done_o),
        .dig3_o(d3), .dig2_o(d2), .dig1_o(d1), .dig0_o(d0)
    );

    signed_dec_formatter #(.W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .value_i(v16),
`ifdef SEVSEG_HEX_MODE_EN
        .hex_i(1'b0),
`endif
        .valid_i(valid16), .ready_o(ready16), .done_o(done16),
        .dig3_o(e3), .dig2_o(e2), .dig1_o(e1), .dig0_o(e0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] exp_dec(input int v);
        int m;
        if (v < 0) begin
            m = -v;
            if (m > 999) return DASH4;
            return {5'd16, 5'(m / 100), 5'(m / 10 % 10), 5'(m % 10)};
        end
        if (v > 9999) return DASH4;
        return {5'(v / 1000), 5'(v / 100 % 10), 5'(v / 10 % 10), 5'(v % 10)};
    endfunction

    task automatic send(input int v, input bit track);
        int n = 0;
        while (ready_o !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_wait", 32'(n < 100), 1);
        value_i = v[W-1:0];
        valid_i = 1'b1;
        if (track) exp_q.push_back(exp_dec(v));
        @(posedge clk); #1;
        valid_i = 1'b0;
        value_i = W'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("done_timeout", 32'(n < 100), 1);
        @(posedge clk); #1;
    endtask

    task automatic run16(input int v);
        v16 = v[15:0];
        valid16 = 1'b1;
        @(posedge clk); #1;
        valid16 = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        chk("w16_done", 32'(done16), 1);
        chk("w16_digits", 32'({e3, e2, e1, e0}), 32'(exp_dec(v)));
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && done_o) begin
            chk("done_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("digits", 32'({d3, d2, d1, d0}), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready_o), 1);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_digits", 32'({d3, d2, d1, d0}), 32'(DASH4));
        rst_n = 1'b1;
        send(1234, 1'b1);
        for (int i = 0; i < 13; i++) begin
            chk("busy_ready", 32'(ready_o), 0);
            chk("busy_done", 32'(done_o), 0);
            @(posedge clk); #1;
        end
        chk("lat_done", 32'(done_o), 1);
        chk("lat_ready", 32'(ready_o), 1);
        chk("lat_digits", 32'({d3, d2, d1, d0}), 32'({5'd1, 5'd2, 5'd3, 5'd4}));
        wait_idle();
        send(-45, 1'b1);   wait_idle();
        send(0, 1'b1);     wait_idle();
        send(-999, 1'b1);  wait_idle();
        send(-1000, 1'b1); wait_idle();
        send(-2048, 1'b1); wait_idle();
        send(2047, 1'b1);  wait_idle();
        chk("hold_digits", 32'({d3, d2, d1, d0}), 32'({5'd2, 5'd0, 5'd4, 5'd7}));
        for (int i = 0; i < 3 * (W + 2); i++) begin
            value_i = W'(i * 37 - 700);
            valid_i = 1'b1;
            if (i % (W + 2) == 0) exp_q.push_back(exp_dec(i * 37 - 700));
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        wait_idle();
        send(777, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_digits", 32'({d3, d2, d1, d0}), 32'(DASH4));
        chk("midrst_ready", 32'(ready_o), 1);
        chk("midrst_done", 32'(done_o), 0);
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_hold", 32'(done_o), 0);
        rst_n = 1'b1;
        send(5, 1'b1);
        wait_idle();
        repeat (20) @(posedge clk);
        #1;
        run16(12000);
        run16(9999);
        run16(10000);
        run16(-32768);
        run16(-999);
`ifdef SEVSEG_HEX_MODE_EN
        hex_i = 1'b1;
        value_i = 12'hA3F;
        valid_i = 1'b1;
        exp_q.push_back({5'd0, 5'd10, 5'd3, 5'd15});
        @(posedge clk); #1;
        valid_i = 1'b0;
        hex_i = 1'b0;
        @(posedge clk); #1;
        chk("hex_done", 32'(done_o), 1);
        chk("hex_ready", 32'(ready_o), 1);
        wait_idle();
        send(-45, 1'b1);
        wait_idle();
`endif
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
